// File: rtl/tlb_op_sequencer_pkg.sv
// Shared TLB maintenance definitions: op codes, INVTLB match codes, sizes and
// the sequencer state encoding.
package csr_tlbDefines;

  localparam int TLBNUM     = 16;
  localparam int TLBNUMSIZE = 4;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } op_type_t;

  // Per-entry match rule the TLB applies for each INVTLB op; 7 and above do not exist.
  typedef enum logic [2:0] {
    INV_ALL        = 3'd0,
    INV_ALL_ALT    = 3'd1,
    INV_G1         = 3'd2,
    INV_G0         = 3'd3,
    INV_G0_ASID    = 3'd4,
    INV_G0_ASID_VA = 3'd5,
    INV_GASID_VA   = 3'd6
  } inv_cmd_t;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S_REQ  = 3'd1,
    ST_S_CAP  = 3'd2,
    ST_R_REQ  = 3'd3,
    ST_R_CAP  = 3'd4,
    ST_W      = 3'd5,
    ST_I_WALK = 3'd6,
    ST_I_BAD  = 3'd7
  } state_t;

  function automatic logic inv_op_bad(input logic [4:0] op);
    return op > INV_OP_MAX;
  endfunction

endpackage

// File: rtl/tlb_op_sequencer_inv_walker.sv
// INVTLB walker: after start, visits every TLB entry once, one per cycle, and
// flags the final entry so the sequencer can finish the op in that same cycle.
module tlb_inv_walker #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  inv_en,
  output logic [TLBNUMSIZE-1:0] inv_idx,
  output logic                  last
);

  localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

  logic                  active;
  logic [TLBNUMSIZE-1:0] walk_ctr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      walk_ctr <= '0;
    end else if (start) begin
      active   <= 1'b1;
      walk_ctr <= '0;
    end else if (active) begin
      if (walk_ctr == LAST_IDX) begin
        active   <= 1'b0;
        walk_ctr <= '0;
      end else begin
        walk_ctr <= walk_ctr + 1'b1;
      end
    end
  end

  assign inv_en  = active;
  assign inv_idx = active ? walk_ctr : '0;
  assign last    = active && (walk_ctr == LAST_IDX);

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from WB onto the TLB ports and
// returns the CSR update strobes; one op in flight, busy until op_done.
module tlb_op_sequencer #(
  parameter int TLBNUM     = csr_tlbDefines::TLBNUM,
  parameter int TLBNUMSIZE = csr_tlbDefines::TLBNUMSIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op_type,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  output logic                  op_ready,
  output logic                  busy,
  output logic                  op_done,
  output logic                  inv_ine,
  input  logic [9:0]            csr_asid,
  input  logic [18:0]           csr_vppn,
  input  logic [TLBNUMSIZE-1:0] csr_index,
  input  logic                  csr_ne,
  input  logic                  csr_ecode_tlbr,
  output logic                  s_req,
  output logic [18:0]           s_vppn,
  output logic [9:0]            s_asid,
  input  logic                  s_hit,
  input  logic [TLBNUMSIZE-1:0] s_index,
  output logic                  s1e,
  output logic [TLBNUMSIZE-1:0] s1_index,
  output logic                  s1_ne,
  output logic                  rd_req,
  output logic [TLBNUMSIZE-1:0] rd_index,
  output logic                  re,
  output logic                  we,
  output logic [TLBNUMSIZE-1:0] wr_index,
  output logic                  wr_e,
  output logic                  inv_en,
  output logic [TLBNUMSIZE-1:0] inv_idx,
  output logic [2:0]            inv_cmd,
  output logic [9:0]            inv_asid_o,
  output logic [18:0]           inv_va_o,
  output logic [2:0]            dbg_state
);

  import csr_tlbDefines::*;

  // Handshake: an op transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE (and not in the first cycle out of reset),
  // op_valid while busy is ignored, and WB holds the op until it transfers.

  state_t                state_q, state_d;
  logic                  armed_q;
  logic                  fill_op_q;
  logic [2:0]            inv_cmd_q;
  logic [9:0]            inv_asid_q;
  logic [18:0]           inv_va_q;
  logic [TLBNUMSIZE-1:0] fill_ctr;
  logic                  accept;
  logic                  walk_start;
  logic                  walk_last;

  assign op_ready   = armed_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = op_valid && op_ready;
  assign inv_cmd    = inv_cmd_q;
  assign inv_asid_o = inv_asid_q;
  assign inv_va_o   = inv_va_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      fill_ctr   <= '0;
      fill_op_q  <= 1'b0;
      inv_cmd_q  <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      fill_ctr <= fill_ctr + 1'b1;
      if (accept) begin
        fill_op_q  <= (op_type == OP_FILL);
        inv_cmd_q  <= inv_op[2:0];
        inv_asid_q <= inv_asid;
        inv_va_q   <= inv_va;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_type)
            OP_SRCH:         state_d = ST_S_REQ;
            OP_RD:           state_d = ST_R_REQ;
            OP_WR, OP_FILL:  state_d = ST_W;
            OP_INV: begin
              if (inv_op_bad(inv_op)) begin
                state_d = ST_I_BAD;
              end else begin
                state_d    = ST_I_WALK;
                walk_start = 1'b1;
              end
            end
            // Undefined op codes are consumed as no-ops.
            default:         state_d = ST_IDLE;
          endcase
        end
      end
      ST_S_REQ:  state_d = ST_S_CAP;
      ST_R_REQ:  state_d = ST_R_CAP;
      ST_I_WALK: if (walk_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_done  = 1'b0;
    inv_ine  = 1'b0;
    s_req    = 1'b0;
    s_vppn   = '0;
    s_asid   = '0;
    s1e      = 1'b0;
    s1_index = '0;
    s1_ne    = 1'b0;
    rd_req   = 1'b0;
    rd_index = '0;
    re       = 1'b0;
    we       = 1'b0;
    wr_index = '0;
    wr_e     = 1'b0;
    case (state_q)
      ST_S_REQ: begin
        s_req  = 1'b1;
        s_vppn = csr_vppn;
        s_asid = csr_asid;
      end
      ST_S_CAP: begin
        // A miss rewrites the current index unchanged and only sets NE.
        s1e      = 1'b1;
        s1_index = s_hit ? s_index : csr_index;
        s1_ne    = ~s_hit;
        op_done  = 1'b1;
      end
      ST_R_REQ: begin
        rd_req   = 1'b1;
        rd_index = csr_index;
      end
      ST_R_CAP: begin
        re      = 1'b1;
        op_done = 1'b1;
      end
      ST_W: begin
        we       = 1'b1;
        wr_index = fill_op_q ? fill_ctr : csr_index;
        wr_e     = csr_ecode_tlbr | ~csr_ne;
        op_done  = 1'b1;
      end
      ST_I_WALK: op_done = walk_last;
      ST_I_BAD: begin
        inv_ine = 1'b1;
        op_done = 1'b1;
      end
      default: ;
    endcase
  end

  tlb_inv_walker #(
    .TLBNUM    (TLBNUM),
    .TLBNUMSIZE(TLBNUMSIZE)
  ) u_inv_walker (
    .clk    (clk),
    .reset  (reset),
    .start  (walk_start),
    .inv_en (inv_en),
    .inv_idx(inv_idx),
    .last   (walk_last)
  );

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: directed vector table, reset-mid-walk sequence
// and randomized ops checked against a latency/strobe reference model.
module tb_tlb_op_sequencer;

  localparam int TLBNUM = 16;

  typedef struct {
    logic [2:0]  op_type;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_va;
    logic [18:0] csr_vppn;
    logic [9:0]  csr_asid;
    logic [3:0]  csr_index;
    logic        csr_ne;
    logic        csr_ecode_tlbr;
    logic        s_hit;
    logic [3:0]  s_index;
    logic        align_fill;
    int          exp_lat;
    int          exp_idx;   // -1: taken from the free-running fill counter
    logic        exp_flag;  // s1_ne for SRCH, wr_e for WR/FILL
    logic        exp_ine;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_va;
  logic        op_ready, busy, op_done, inv_ine;
  logic [9:0]  csr_asid;
  logic [18:0] csr_vppn;
  logic [3:0]  csr_index;
  logic        csr_ne, csr_ecode_tlbr;
  logic        s_req;
  logic [18:0] s_vppn;
  logic [9:0]  s_asid;
  logic        s_hit;
  logic [3:0]  s_index;
  logic        s1e;
  logic [3:0]  s1_index;
  logic        s1_ne, rd_req;
  logic [3:0]  rd_index;
  logic        re, we;
  logic [3:0]  wr_index;
  logic        wr_e, inv_en;
  logic [3:0]  inv_idx;
  logic [2:0]  inv_cmd;
  logic [9:0]  inv_asid_o;
  logic [18:0] inv_va_o;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  tlb_op_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .op_ready(op_ready), .busy(busy), .op_done(op_done), .inv_ine(inv_ine),
    .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index),
    .csr_ne(csr_ne), .csr_ecode_tlbr(csr_ecode_tlbr),
    .s_req(s_req), .s_vppn(s_vppn), .s_asid(s_asid),
    .s_hit(s_hit), .s_index(s_index),
    .s1e(s1e), .s1_index(s1_index), .s1_ne(s1_ne),
    .rd_req(rd_req), .rd_index(rd_index), .re(re),
    .we(we), .wr_index(wr_index), .wr_e(wr_e),
    .inv_en(inv_en), .inv_idx(inv_idx), .inv_cmd(inv_cmd),
    .inv_asid_o(inv_asid_o), .inv_va_o(inv_va_o), .dbg_state(dbg_state)
  );

  logic [127:0] all_outs;
  assign all_outs = {36'd0, op_ready, busy, op_done, inv_ine, s_req, s_vppn, s_asid,
                     s1e, s1_index, s1_ne, rd_req, rd_index, re, we, wr_index, wr_e,
                     inv_en, inv_idx, inv_cmd, inv_asid_o, inv_va_o, dbg_state};

  // Clock edges seen out of reset: the expected fill counter value.
  int fill_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) fill_cnt <= 0;
    else        fill_cnt <= fill_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    e.exp_idx  = 0;
    e.exp_flag = 1'b0;
    e.exp_ine  = 1'b0;
    case (v.op_type)
      3'd0: begin
        e.exp_lat  = 2;
        e.exp_idx  = v.s_hit ? int'(v.s_index) : int'(v.csr_index);
        e.exp_flag = ~v.s_hit;
      end
      3'd1: begin
        e.exp_lat = 2;
        e.exp_idx = int'(v.csr_index);
      end
      3'd2, 3'd3: begin
        e.exp_lat  = 1;
        e.exp_idx  = (v.op_type == 3'd3) ? -1 : int'(v.csr_index);
        e.exp_flag = v.csr_ecode_tlbr | ~v.csr_ne;
      end
      default: begin
        if (v.inv_op > 5'd6) begin
          e.exp_lat = 1;
          e.exp_ine = 1'b1;
        end else begin
          e.exp_lat = TLBNUM;
        end
      end
    endcase
    return e;
  endfunction

  function automatic vec_t mkv(input logic [2:0] ot, input logic [4:0] iop, input logic [9:0] ias,
                               input logic [18:0] iva, input logic [18:0] vppn, input logic [9:0] asid,
                               input logic [3:0] cidx, input logic ne, input logic tlbr, input logic hit,
                               input logic [3:0] sidx, input logic align, input int lat, input int idx,
                               input logic flag, input logic ine);
    vec_t v;
    v.op_type = ot;  v.inv_op = iop;  v.inv_asid = ias;  v.inv_va = iva;
    v.csr_vppn = vppn;  v.csr_asid = asid;  v.csr_index = cidx;
    v.csr_ne = ne;  v.csr_ecode_tlbr = tlbr;  v.s_hit = hit;  v.s_index = sidx;
    v.align_fill = align;  v.exp_lat = lat;  v.exp_idx = idx;
    v.exp_flag = flag;  v.exp_ine = ine;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, ".ready_wait"}, 128'(op_ready), 128'(1));
  endtask

  task automatic run_op(input vec_t v, input logic hold, input string name);
    logic is_s, is_r, is_w, is_i, is_b;
    int   fill_now = 0;
    int   exp_w;
    is_s = (v.op_type == 3'd0);
    is_r = (v.op_type == 3'd1);
    is_w = (v.op_type == 3'd2) || (v.op_type == 3'd3);
    is_i = (v.op_type == 3'd4) && (v.inv_op <= 5'd6);
    is_b = (v.op_type == 3'd4) && (v.inv_op > 5'd6);
    @(negedge clk);
    wait_ready(name);
    if (v.align_fill) begin
      int n = 0;
      while ((fill_cnt % TLBNUM) != TLBNUM - 1 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    op_type = v.op_type;  inv_op = v.inv_op;  inv_asid = v.inv_asid;  inv_va = v.inv_va;
    csr_vppn = v.csr_vppn;  csr_asid = v.csr_asid;  csr_index = v.csr_index;
    csr_ne = v.csr_ne;  csr_ecode_tlbr = v.csr_ecode_tlbr;
    s_hit = v.s_hit;  s_index = v.s_index;
    op_valid = 1'b1;
    for (int c = 1; c <= v.exp_lat; c++) begin
      string p;
      @(negedge clk);
      p = $sformatf("%s.c%0d", name, c);
      if (c == 1) fill_now = fill_cnt % TLBNUM;
      check({p, ".onehot"}, 128'($countones({s_req, rd_req, we, inv_en}) <= 1), 128'(1));
      check({p, ".busy"}, 128'({busy, op_ready}), 128'(2'b10));
      check({p, ".op_done"}, 128'(op_done), 128'(c == v.exp_lat));
      check({p, ".strobes"}, 128'({s_req, s1e, rd_req, re, we, inv_en, inv_ine}),
            128'({is_s && c == 1, is_s && c == 2, is_r && c == 1, is_r && c == 2,
                  is_w && c == 1, is_i, is_b && c == 1}));
      if (is_s && c == 1) check({p, ".s_key"}, 128'({s_vppn, s_asid}), 128'({v.csr_vppn, v.csr_asid}));
      if (is_s && c == 2) check({p, ".s1"}, 128'({s1_index, s1_ne}), 128'({4'(v.exp_idx), v.exp_flag}));
      if (is_r && c == 1) check({p, ".rd_index"}, 128'(rd_index), 128'(v.exp_idx));
      if (is_w) begin
        exp_w = (v.exp_idx < 0) ? fill_now : v.exp_idx;
        check({p, ".wr"}, 128'({wr_index, wr_e}), 128'({4'(exp_w), v.exp_flag}));
      end
      if (is_i) begin
        check({p, ".inv_idx"}, 128'(inv_idx), 128'(c - 1));
        check({p, ".inv_latch"}, 128'({inv_cmd, inv_asid_o, inv_va_o}),
              128'({v.inv_op[2:0], v.inv_asid, v.inv_va}));
      end
      if (!hold || c == v.exp_lat) begin
        op_valid = 1'b0;
      end else begin
        // WB-side noise while busy must not be taken as a new op.
        op_type  = 3'($urandom_range(0, 4));
        inv_op   = 5'($urandom_range(0, 31));
        inv_asid = 10'($urandom);
        inv_va   = 19'($urandom);
      end
    end
    @(negedge clk);
    check({name, ".idle"}, 128'({op_ready, busy, op_done, inv_ine, inv_en}), 128'(5'b10000));
  endtask

  // ---------------- test ----------------
  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = mkv(3'd0, 5'd0, 10'd0, 19'd0, 19'h12345, 10'h055, 4'd3, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 2, 7, 1'b0, 1'b0);
    vecs[1]  = mkv(3'd0, 5'd0, 10'd0, 19'd0, 19'h0ABCD, 10'h155, 4'd3, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 2, 3, 1'b1, 1'b0);
    vecs[2]  = mkv(3'd1, 5'd0, 10'd0, 19'd0, 19'h00000, 10'h000, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2, 9, 1'b0, 1'b0);
    vecs[3]  = mkv(3'd3, 5'd0, 10'd0, 19'd0, 19'h00000, 10'h000, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1, 0, 1'b1, 1'b0);
    vecs[4]  = mkv(3'd2, 5'd0, 10'd0, 19'd0, 19'h00000, 10'h000, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1, 5, 1'b0, 1'b0);
    vecs[5]  = mkv(3'd2, 5'd0, 10'd0, 19'd0, 19'h00000, 10'h000, 4'd12, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 12, 1'b1, 1'b0);
    vecs[6]  = mkv(3'd4, 5'd5, 10'h02A, 19'h7ABCD, 19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16, 0, 1'b0, 1'b0);
    vecs[7]  = mkv(3'd4, 5'd7, 10'h02A, 19'h7ABCD, 19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 0, 1'b0, 1'b1);
    vecs[8]  = mkv(3'd4, 5'd0, 10'h3FF, 19'h00001, 19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16, 0, 1'b0, 1'b0);
    vecs[9]  = mkv(3'd4, 5'd31, 10'h001, 19'h40000, 19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 0, 1'b0, 1'b1);
    vecs[10] = mkv(3'd4, 5'd6, 10'h155, 19'h2AAAA, 19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16, 0, 1'b0, 1'b0);

    reset = 1'b0;  op_valid = 1'b0;  op_type = 3'd0;  inv_op = 5'd0;
    inv_asid = 10'd0;  inv_va = 19'd0;  csr_asid = 10'd0;  csr_vppn = 19'd0;
    csr_index = 4'd0;  csr_ne = 1'b0;  csr_ecode_tlbr = 1'b0;  s_hit = 1'b0;  s_index = 4'd0;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'({op_ready, busy}), 128'(2'b10));

    for (int i = 0; i < 11; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset asserted in the middle of an INVTLB walk.
    @(negedge clk);
    wait_ready("rst_walk");
    op_type = 3'd4;  inv_op = 5'd5;  inv_asid = 10'h02A;  inv_va = 19'h01234;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_walk.pre_idx", 128'({inv_en, inv_idx, op_done}), 128'({1'b1, 4'd6, 1'b0}));
    #2 reset = 1'b0;
    #1 check("rst_walk.async_zero", all_outs, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_walk.held%0d", i), all_outs, 128'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_walk.after_release", 128'({op_ready, busy, op_done, inv_en}), 128'(4'b1000));
    run_op(vecs[0], 1'b0, "rst_walk.srch");

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.op_type        = 3'($urandom_range(0, 4));
      v.inv_op         = 5'($urandom_range(0, 9));
      v.inv_asid       = 10'($urandom);
      v.inv_va         = 19'($urandom);
      v.csr_vppn       = 19'($urandom);
      v.csr_asid       = 10'($urandom);
      v.csr_index      = 4'($urandom);
      v.csr_ne         = 1'($urandom_range(0, 1));
      v.csr_ecode_tlbr = 1'($urandom_range(0, 1));
      v.s_hit          = 1'($urandom_range(0, 1));
      v.s_index        = 4'($urandom);
      v.align_fill     = 1'b0;
      v = model(v);
      run_op(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
